booth_mul_pipe: RTL and testbench

BOOTH_MUL_PIPE -- requirements
Module: booth_mul_pipe

---
 rtl/mul_pkg.sv | 68 ++++++
 rtl/csa_3to2.sv | 26 ++
 rtl/booth_mul_pipe.sv | 164 ++++++++++++++++
 tb/tb_booth_mul_pipe.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mul_pkg                                                              |
// | Shared definitions for the pipelined radix-4 Booth multiplier:       |
// | partial-product count, Booth select encoding, and helpers that size  |
// | the carry-save reduction tree and split it across pipeline stages.   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package mul_pkg;

  localparam int MUL_STAGES = 3;

  // One-hot Booth digit select.
  typedef enum logic [4:0] {
    BSEL_ZERO = 5'b00001,
    BSEL_POS1 = 5'b00010,
    BSEL_POS2 = 5'b00100,
    BSEL_NEG1 = 5'b01000,
    BSEL_NEG2 = 5'b10000
  } booth_sel_e;

  // Number of radix-4 partial products for a given operand width.
  function automatic int npp(input int width);
    return width / 2 + 1;
  endfunction

  // Vectors remaining after one 3:2 level: every full group of three
  // becomes two, leftovers pass through.
  function automatic int csa_next(input int n);
    return n - n / 3;
  endfunction

  // Vector count at the input of tree level lvl.
  function automatic int tree_cnt(input int n, input int lvl);
    int cnt;
    cnt = n;
    for (int i = 0; i < lvl; i++) cnt = csa_next(cnt);
    return cnt;
  endfunction

  // Levels needed to bring n vectors down to two.
  function automatic int tree_levels(input int n);
    int cnt;
    int lvl;
    cnt = n;
    lvl = 0;
    while (cnt > 2) begin
      cnt = csa_next(cnt);
      lvl++;
    end
    return lvl;
  endfunction

  // Radix-4 Booth recoding of the bit triplet {b[2i+1], b[2i], b[2i-1]}.
  function automatic booth_sel_e booth_decode(input logic [2:0] trip);
    booth_sel_e sel;
    case (trip)
      3'b001, 3'b010: sel = BSEL_POS1;
      3'b011:         sel = BSEL_POS2;
      3'b100:         sel = BSEL_NEG2;
      3'b101, 3'b110: sel = BSEL_NEG1;
      default:        sel = BSEL_ZERO;
    endcase
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/csa_3to2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | csa_3to2                                                             |
// | W-bit 3:2 carry-save compressor. s is the bitwise sum, c the carry   |
// | vector already shifted left by one (top carry falls off, modulo 2^W).|
// | Ports: x, y, z in [W-1:0]; s, c out [W-1:0].                         |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module csa_3to2 #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] s,
  output logic [W-1:0] c
);

  logic [W-2:0] maj;

  assign s   = x ^ y ^ z;
  assign maj = (x[W-2:0] & y[W-2:0]) | (x[W-2:0] & z[W-2:0]) | (y[W-2:0] & z[W-2:0]);
  assign c   = {maj, 1'b0};

endmodule
`default_nettype wire

// File: rtl/booth_mul_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | booth_mul_pipe                                                       |
// | 3-stage pipelined radix-4 Booth multiplier, signed or unsigned, with |
// | valid/ready handshakes on both sides, a sideband tag and flush.      |
// | Ports: mul_clk, reset (async, active high); in_valid/in_ready,       |
// | mul_signed, A, B, in_tag (operand beat); flush; out_valid/out_ready, |
// | result, out_tag (product beat); busy (any stage occupied).           |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module booth_mul_pipe
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic               mul_clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               mul_signed,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);

  localparam int NPP    = npp(WIDTH);
  localparam int PW     = 2 * WIDTH;
  localparam int N_LVL  = tree_levels(NPP);
  localparam int SPLIT  = (N_LVL + 1) / 2;     // levels below SPLIT live in S2
  localparam int S2_CNT = tree_cnt(NPP, SPLIT);

  // ---------------- handshake / valid pipeline ----------------
  logic s1_valid, s2_valid, s3_valid;
  logic s1_adv, s2_adv, s3_adv;

  assign s3_adv    = !s3_valid || out_ready;
  assign s2_adv    = !s2_valid || s3_adv;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s3_valid;
  assign busy      = s1_valid | s2_valid | s3_valid;

  // ---------------- stage 1 registers ----------------
  logic [WIDTH-1:0] s1_a, s1_b;
  logic             s1_signed;
  logic [TAG_W-1:0] s1_tag;

  // ---------------- Booth partial products (S2 comb) ----------------
  logic [PW-1:0]    a_ext;
  logic [WIDTH+2:0] b_code;   // extended multiplier with implicit b[-1] = 0

  assign a_ext  = {{(PW-WIDTH){s1_signed & s1_a[WIDTH-1]}}, s1_a};
  assign b_code = {{2{s1_signed & s1_b[WIDTH-1]}}, s1_b, 1'b0};

  // tree[l] holds the vectors entering level l; lvl_in[l] is what level l
  // actually reduces (the S2 register output at the split level).
  logic [PW-1:0] tree   [0:N_LVL][0:NPP-1];
  logic [PW-1:0] lvl_in [0:N_LVL-1][0:NPP-1];
  logic [PW-1:0] s2_vec [0:S2_CNT-1];
  logic [TAG_W-1:0] s2_tag;

  for (genvar i = 0; i < NPP; i++) begin : g_pp
    booth_sel_e    sel;
    logic [PW-1:0] mult;

    assign sel = booth_decode(b_code[2*i+2 -: 3]);

    always_comb begin
      mult = '0;
      case (sel)
        BSEL_POS1: mult = a_ext;
        BSEL_POS2: mult = a_ext << 1;
        BSEL_NEG1: mult = -a_ext;
        BSEL_NEG2: mult = -(a_ext << 1);
        default:   mult = '0;
      endcase
    end

    assign tree[0][i] = mult << (2 * i);
  end

  // ---------------- carry-save reduction tree ----------------
  for (genvar l = 0; l < N_LVL; l++) begin : g_lvl
    localparam int N  = tree_cnt(NPP, l);
    localparam int G  = N / 3;
    localparam int NN = N - G;

    for (genvar j = 0; j < N; j++) begin : g_src
      if (l == SPLIT) begin : g_from_reg
        assign lvl_in[l][j] = s2_vec[j];
      end else begin : g_from_comb
        assign lvl_in[l][j] = tree[l][j];
      end
    end

    for (genvar g = 0; g < G; g++) begin : g_csa
      csa_3to2 #(.W(PW)) u_csa (
        .x (lvl_in[l][3*g]),
        .y (lvl_in[l][3*g+1]),
        .z (lvl_in[l][3*g+2]),
        .s (tree[l+1][2*g]),
        .c (tree[l+1][2*g+1])
      );
    end

    for (genvar r = 0; r < N - 3*G; r++) begin : g_pass
      assign tree[l+1][2*G+r] = lvl_in[l][3*G+r];
    end

    for (genvar j = NN; j < NPP; j++) begin : g_zero
      assign tree[l+1][j] = '0;
    end
  end

  logic [PW-1:0] sum;
  assign sum = tree[N_LVL][0] + tree[N_LVL][1];

  // ---------------- data registers (load only when occupied) ----------------
  always_ff @(posedge mul_clk) begin
    if (s1_adv && in_valid && !flush) begin
      s1_a      <= A;
      s1_b      <= B;
      s1_signed <= mul_signed;
      s1_tag    <= in_tag;
    end
    if (s2_adv && s1_valid && !flush) begin
      s2_tag <= s1_tag;
      for (int j = 0; j < S2_CNT; j++) s2_vec[j] <= tree[SPLIT][j];
    end
  end

  // ---------------- valid bits and output stage ----------------
  always_ff @(posedge mul_clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      result   <= '0;
      out_tag  <= '0;
    end else if (flush) begin
      // An output handshake in this cycle still completes at this edge.
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      if (s1_adv) s1_valid <= in_valid;
      if (s2_adv) s2_valid <= s1_valid;
      if (s3_adv) s3_valid <= s2_valid;
      if (s3_adv && s2_valid) begin
        result  <= sum;
        out_tag <= s2_tag;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_booth_mul_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_booth_mul_pipe                                                    |
// | Self-checking bench: 32-bit directed table and sequences plus random |
// | traffic, and 8/16-bit random sweeps against an arithmetic reference. |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_booth_mul_pipe;
  import mul_pkg::*;

  typedef struct {
    logic [3:0]  tag;
    logic [63:0] prod;
  } exp_t;

  typedef struct {
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [63:0] prod;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Exact product of w-bit operands, reduced to 2w bits.
  function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                          input int w, input bit s);
    logic [63:0] mw, m, ea, eb;
    mw = (64'd1 << w) - 64'd1;
    m  = (w >= 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
    ea = a & mw;
    eb = b & mw;
    if (s && a[w-1]) ea = ea | ~mw;
    if (s && b[w-1]) eb = eb | ~mw;
    return (ea * eb) & m;
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [31:0] v, mw;
    mw = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case ($urandom % 6)
      0:       v = 32'd0;
      1:       v = 32'd1;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'd1 << (w - 1);
      4:       v = (32'd1 << (w - 1)) - 32'd1;
      default: v = $urandom;
    endcase
    return v & mw;
  endfunction

  // ---------------- 32-bit DUT ----------------
  logic        m_rst, m_iv, m_ir, m_sg, m_fl, m_ov, m_or, m_busy;
  logic [31:0] m_a, m_b;
  logic [3:0]  m_tg, m_otg;
  logic [63:0] m_res;

  booth_mul_pipe #(.WIDTH(32), .TAG_W(4)) u_dut32 (
    .mul_clk(clk), .reset(m_rst), .in_valid(m_iv), .in_ready(m_ir),
    .mul_signed(m_sg), .A(m_a), .B(m_b), .in_tag(m_tg), .flush(m_fl),
    .out_valid(m_ov), .out_ready(m_or), .result(m_res), .out_tag(m_otg),
    .busy(m_busy)
  );

  exp_t        q[$];
  int          n_out = 0;
  bit          hold_v = 0;
  bit          last_ir = 0;
  logic [63:0] hold_res;
  logic [3:0]  hold_tag;

  // One cycle: sample handshakes at the falling edge, update the model,
  // then return just after the next rising edge.
  task automatic step(output bit acc);
    exp_t e;
    @(negedge clk);
    acc     = 0;
    last_ir = m_ir;
    if (hold_v) begin
      chk("stall_valid", m_ov, 1);
      chk("stall_result", m_res, hold_res);
      chk("stall_tag", m_otg, hold_tag);
    end
    if (m_ov && m_or) begin
      n_out++;
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL extra_output: got result 0x%0h, want no beat", m_res);
      end else begin
        e = q.pop_front();
        chk("sb_result", m_res, e.prod);
        chk("sb_tag", m_otg, e.tag);
      end
    end
    if (m_fl) q.delete();
    else if (m_iv && m_ir) begin
      acc    = 1;
      e.tag  = m_tg;
      e.prod = ref_mul(m_a, m_b, 32, m_sg);
      q.push_back(e);
    end
    hold_v   = m_ov && !m_or && !m_fl;
    hold_res = m_res;
    hold_tag = m_otg;
    @(posedge clk);
    #1;
  endtask

  // ---------------- 8/16-bit random sweeps ----------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_sweep
    localparam int SW = (gi == 0) ? 8 : 16;
    logic            rst, iv, ir, sg, fl, ov, ordy, busy;
    logic [SW-1:0]   a, b;
    logic [3:0]      tg, otg;
    logic [2*SW-1:0] res;
    logic            done;
    exp_t            sq[$];

    booth_mul_pipe #(.WIDTH(SW), .TAG_W(4)) u_dut (
      .mul_clk(clk), .reset(rst), .in_valid(iv), .in_ready(ir),
      .mul_signed(sg), .A(a), .B(b), .in_tag(tg), .flush(fl),
      .out_valid(ov), .out_ready(ordy), .result(res), .out_tag(otg),
      .busy(busy)
    );

    initial begin
      exp_t e;
      done = 0; rst = 1; iv = 0; sg = 0; fl = 0; a = '0; b = '0; tg = '0; ordy = 0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 0;
      @(posedge clk);
      #1;
      for (int c = 0; c < 3010; c++) begin
        if (c < 3000) begin
          iv   = ($urandom % 4) != 0;
          sg   = 1'($urandom % 2);
          a    = SW'(pick(SW));
          b    = SW'(pick(SW));
          tg   = 4'($urandom);
          ordy = ($urandom % 3) != 0;
        end else begin
          iv   = 0;
          ordy = 1;
        end
        @(negedge clk);
        if (ov && ordy) begin
          if (sq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sweep%0d_extra: got result 0x%0h, want no beat", SW, res);
          end else begin
            e = sq.pop_front();
            chk($sformatf("sweep%0d_result", SW), 64'(res), e.prod);
            chk($sformatf("sweep%0d_tag", SW), otg, e.tag);
          end
        end
        if (iv && ir) begin
          e.tag  = tg;
          e.prod = ref_mul(64'(a), 64'(b), SW, sg);
          sq.push_back(e);
        end
        @(posedge clk);
        #1;
      end
      chk($sformatf("sweep%0d_drained", SW), sq.size(), 0);
      done = 1;
    end
  end

  // ---------------- 32-bit directed and random flow ----------------
  vec_t        tbl[11];
  logic [31:0] ba[5], bb[5];

  initial begin
    bit acc;
    int lat, sent, base;

    m_rst = 1; m_iv = 0; m_sg = 0; m_a = '0; m_b = '0; m_tg = '0; m_fl = 0; m_or = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", m_ov, 0);
    chk("reset_busy", m_busy, 0);
    chk("reset_in_ready", m_ir, 1);
    chk("reset_result", m_res, 0);
    chk("reset_out_tag", m_otg, 0);
    @(negedge clk) m_rst = 0;
    @(posedge clk);
    #1;

    tbl[0]  = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3,  64'h0000_0000_0000_0001};
    tbl[1]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5,  64'hFFFF_FFFE_0000_0001};
    tbl[2]  = '{1'b1, 32'h8000_0000, 32'h8000_0000, 4'd7,  64'h4000_0000_0000_0000};
    tbl[3]  = '{1'b1, 32'h8000_0000, 32'h0000_0001, 4'd9,  64'hFFFF_FFFF_8000_0000};
    tbl[4]  = '{1'b0, 32'h8000_0000, 32'h0000_0002, 4'd1,  64'h0000_0001_0000_0000};
    tbl[5]  = '{1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 4'd2,  64'hC000_0000_8000_0000};
    tbl[6]  = '{1'b0, 32'h1234_5678, 32'h0000_0000, 4'd4,  64'h0000_0000_0000_0000};
    tbl[7]  = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 4'd6,  64'hFFFF_FFFF_FFFF_FFFE};
    tbl[8]  = '{1'b0, 32'h0001_0000, 32'h0001_0000, 4'd8,  64'h0000_0001_0000_0000};
    tbl[9]  = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 4'd15, 64'h0000_0000_FFFF_FFFF};
    tbl[10] = '{1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'd10, 64'h3FFF_FFFF_0000_0001};

    // Single beats: offered in the cycle after edge N, visible after edge N+3.
    for (int i = 0; i < 11; i++) begin
      m_iv = 1; m_sg = tbl[i].sgn; m_a = tbl[i].a; m_b = tbl[i].b; m_tg = tbl[i].tag; m_or = 1;
      @(negedge clk);
      chk($sformatf("tbl%0d_in_ready", i), m_ir, 1);
      @(posedge clk);
      #1;
      m_iv = 0;
      lat = 1;
      while (lat < 10) begin
        @(negedge clk);
        if (m_ov) break;
        @(posedge clk);
        #1;
        lat++;
      end
      chk($sformatf("tbl%0d_latency", i), lat, MUL_STAGES);
      chk($sformatf("tbl%0d_result", i), m_res, tbl[i].prod);
      chk($sformatf("tbl%0d_tag", i), m_otg, tbl[i].tag);
      @(posedge clk);
      #1;
    end

    // Back-to-back five beats, output stalled in cycles 4..9.
    for (int i = 0; i < 5; i++) begin
      ba[i] = $urandom;
      bb[i] = $urandom;
    end
    sent = 0;
    base = n_out;
    for (int c = 1; c <= 16; c++) begin
      m_iv = (sent < 5);
      if (sent < 5) begin
        m_a = ba[sent]; m_b = bb[sent]; m_tg = 4'(sent + 8); m_sg = sent[0];
      end
      m_or = !(c >= 4 && c <= 9);
      step(acc);
      if (acc) sent++;
      if (c == 4) begin
        chk("b2b_in_ready_low", last_ir, 0);
        chk("b2b_held_beats", sent, 3);
      end
    end
    m_iv = 0;
    chk("b2b_out_count", n_out - base, 5);
    chk("b2b_queue_empty", q.size(), 0);

    // Random traffic with occasional flush.
    for (int c = 0; c < 400; c++) begin
      m_iv = ($urandom % 3) != 0;
      m_sg = 1'($urandom % 2);
      m_a  = pick(32);
      m_b  = pick(32);
      m_tg = 4'($urandom);
      m_or = ($urandom % 4) != 0;
      m_fl = ($urandom % 40) == 0;
      step(acc);
    end
    m_iv = 0; m_fl = 0; m_or = 1;
    repeat (8) step(acc);
    chk("rand32_drained", q.size(), 0);

    // Flush with three beats in flight and output stalled.
    base = n_out;
    m_or = 0;
    for (int c = 0; c < 3; c++) begin
      m_iv = 1; m_a = $urandom; m_b = $urandom; m_tg = 4'(c); m_sg = 1;
      step(acc);
      chk("flush_fill_accept", acc, 1);
    end
    m_fl = 1; m_iv = 1; m_a = 32'd5; m_b = 32'd7;
    step(acc);
    m_fl = 0; m_iv = 0;
    @(negedge clk);
    chk("flush_out_valid", m_ov, 0);
    chk("flush_busy", m_busy, 0);
    chk("flush_in_ready", m_ir, 1);
    @(posedge clk);
    #1;
    m_or = 1;
    repeat (6) step(acc);
    chk("flush_no_stale", n_out - base, 0);

    // Flush coinciding with an output handshake.
    base = n_out;
    m_or = 0;
    for (int c = 0; c < 2; c++) begin
      m_iv = 1; m_a = $urandom; m_b = $urandom; m_tg = 4'(c + 12); m_sg = 0;
      step(acc);
    end
    m_iv = 0;
    step(acc);
    m_or = 1; m_fl = 1;
    step(acc);
    m_fl = 0;
    @(negedge clk);
    chk("flush_hs_out_valid", m_ov, 0);
    chk("flush_hs_busy", m_busy, 0);
    chk("flush_hs_delivered", n_out - base, 1);
    @(posedge clk);
    #1;

    // Asynchronous reset with two beats in flight.
    base = n_out;
    m_or = 0;
    for (int c = 0; c < 2; c++) begin
      m_iv = 1; m_a = $urandom; m_b = $urandom; m_tg = 4'(c + 4); m_sg = 1;
      step(acc);
    end
    m_iv = 0;
    step(acc);
    chk("pre_reset_out_valid", m_ov, 1);
    #2 m_rst = 1;
    #1;
    chk("async_reset_out_valid", m_ov, 0);
    chk("async_reset_busy", m_busy, 0);
    chk("async_reset_in_ready", m_ir, 1);
    chk("async_reset_result", m_res, 0);
    chk("async_reset_tag", m_otg, 0);
    q.delete();
    hold_v = 0;
    @(posedge clk);
    @(negedge clk) m_rst = 0;
    @(posedge clk);
    #1;
    m_or = 1;
    repeat (6) step(acc);
    chk("reset_no_output", n_out - base, 0);

    // Wait for the narrow-width sweeps.
    for (int k = 0; k < 40000 && !(g_sweep[0].done && g_sweep[1].done); k++) @(posedge clk);
    if (!(g_sweep[0].done && g_sweep[1].done)) begin
      n_vec++;
      n_err++;
      $display("FAIL sweep_timeout: got done=%0b%0b, want 11", g_sweep[1].done, g_sweep[0].done);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
